// File: rtl/centroid_moment_pkg.sv
// Shared constants, typedefs and octant encoding for the ORB intensity-centroid
// moment unit.
package centroid_moment_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_SZ   = 37;
  localparam int RAD      = (WIN_SZ - 1) / 2;
  localparam int MOM_BITS = 24;
  localparam int C_W      = 14;
  localparam int Y_W      = 17;
  localparam int S_W      = 19;

  typedef logic [PIX_W-1:0]           pix_t;
  typedef logic [C_W-1:0]             csum_t;
  typedef logic signed [Y_W-1:0]      ysum_t;
  typedef logic [S_W-1:0]             ssum_t;
  typedef logic signed [MOM_BITS-1:0] mom_t;

  typedef struct packed {
    csum_t c;
    ysum_t y;
  } colsum_t;

  typedef struct packed {
    logic y_neg;
    logic x_neg;
    logic y_dom;
  } octant_t;

  function automatic octant_t octant_of(mom_t mx, mom_t my);
    octant_t o;
    int ax;
    int ay;
    ax = (mx < 0) ? -int'(mx) : int'(mx);
    ay = (my < 0) ? -int'(my) : int'(my);
    o.y_neg = my < 0;
    o.x_neg = mx < 0;
    o.y_dom = ay > ax;
    return o;
  endfunction

endpackage

// File: rtl/centroid_col_history.sv
// WIN-deep enabled shift register of per-column {C,Y} sums; dout is the
// column leaving the window.
import centroid_moment_pkg::*;

module centroid_col_history #(
  parameter int DEPTH = WIN_SZ
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    ena,
  input  colsum_t din,
  output colsum_t dout
);

  colsum_t q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (ena) begin
      q[0] <= din;
      for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
    end
  end

  assign dout = q[DEPTH-1];

endmodule

// File: rtl/centroid_moment.sv
// Sliding 37x37 intensity-centroid moments (m10, m01) with frame position.
// Optional `octant` output when CENTROID_OCTANT_EN is defined.
import centroid_moment_pkg::*;

module centroid_moment #(
  parameter int PIXEL_WIDTH = PIX_W,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int WIN         = WIN_SZ,
  parameter int MOM_W       = MOM_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [WIN*PIXEL_WIDTH-1:0]    col_in,
  output logic signed [MOM_W-1:0]       m10,
  output logic signed [MOM_W-1:0]       m01,
  output logic                          mom_valid,
  output logic [9:0]                    cx,
  output logic [8:0]                    cy
`ifdef CENTROID_OCTANT_EN
  ,
  output logic [2:0]                    octant
`endif
);

  localparam int         RR       = (WIN - 1) / 2;
  localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
  localparam logic [8:0] ROW_LAST = 9'(IMG_H - 1);
  localparam logic [9:0] COL_EDGE = 10'(WIN - 1);
  localparam logic [8:0] ROW_EDGE = 9'(WIN - 1);
  localparam logic [9:0] COL_OFF  = 10'(RR);
  localparam logic [8:0] ROW_OFF  = 9'(RR);

  csum_t      c_sum;
  ysum_t      y_sum;
  csum_t      c1;
  ysum_t      y1;
  logic [9:0] col_cnt;
  logic [8:0] row_cnt;
  logic [9:0] pos_col;
  logic [8:0] pos_row;
  colsum_t    hin;
  colsum_t    hout;
  ssum_t      s;
  ssum_t      s_n;
  logic signed [MOM_W-1:0] m10_n;
  logic signed [MOM_W-1:0] m01_n;

  always_comb begin
    int ca;
    int ya;
    ca = 0;
    ya = 0;
    for (int k = 0; k < WIN; k++) begin
      ca += int'(col_in[k*PIXEL_WIDTH +: PIXEL_WIDTH]);
      ya += (k - RR) * int'(col_in[k*PIXEL_WIDTH +: PIXEL_WIDTH]);
    end
    c_sum = csum_t'(ca);
    y_sum = ysum_t'(ya);
  end

  // Stage 1: column sums, tagged with the column's frame position
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c1      <= '0;
      y1      <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      pos_col <= '0;
      pos_row <= '0;
    end else if (ena) begin
      c1      <= c_sum;
      y1      <= y_sum;
      col_cnt <= pos_col;
      row_cnt <= pos_row;
      if (pos_col == COL_LAST) begin
        pos_col <= '0;
        pos_row <= (pos_row == ROW_LAST) ? '0 : pos_row + 9'd1;
      end else begin
        pos_col <= pos_col + 10'd1;
      end
    end
  end

  assign hin = {c1, y1};

  centroid_col_history #(
    .DEPTH (WIN)
  ) u_hist (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .din  (hin),
    .dout (hout)
  );

  // Window shifts left by one: old columns lose one x step each
  always_comb begin
    s_n   = ssum_t'(int'(s) + int'(c1) - int'(hout.c));
    m01_n = MOM_W'(int'(m01) + int'(y1) - int'(hout.y));
    m10_n = MOM_W'(int'(m10) - int'(s)
                   + (RR + 1) * int'(hout.c)
                   + RR * int'(c1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s         <= '0;
      m10       <= '0;
      m01       <= '0;
      mom_valid <= 1'b0;
      cx        <= '0;
      cy        <= '0;
    end else if (ena) begin
      s         <= s_n;
      m10       <= m10_n;
      m01       <= m01_n;
      mom_valid <= (col_cnt >= COL_EDGE) && (row_cnt >= ROW_EDGE);
      cx        <= col_cnt - COL_OFF;
      cy        <= row_cnt - ROW_OFF;
    end else begin
      mom_valid <= 1'b0;
    end
  end

`ifdef CENTROID_OCTANT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      octant <= '0;
    end else if (ena) begin
      octant <= octant_of(mom_t'(m10_n), mom_t'(m01_n));
    end
  end
`endif

endmodule

// File: tb/tb_centroid_moment.sv
// Self-checking bench for centroid_moment against a direct window-sum model.
// Build with +define+CENTROID_OCTANT_EN to also check the octant output.
module tb_centroid_moment;

  localparam int W   = 37;
  localparam int R   = 18;
  localparam int IW  = 640;
  localparam int IH  = 480;
`ifdef CENTROID_OCTANT_EN
  localparam int VW  = 71;
`else
  localparam int VW  = 68;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ena = 1'b0;
  logic [W*8-1:0]     col_in = '0;
  logic signed [23:0] m10;
  logic signed [23:0] m01;
  logic               mom_valid;
  logic [9:0]         cx;
  logic [8:0]         cy;
`ifdef CENTROID_OCTANT_EN
  logic [2:0]         octant;
`endif

  centroid_moment dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .col_in    (col_in),
    .m10       (m10),
    .m01       (m01),
    .mom_valid (mom_valid),
    .cx        (cx),
    .cy        (cy)
`ifdef CENTROID_OCTANT_EN
    ,
    .octant    (octant)
`endif
  );

  always #5 clk = ~clk;

  int         win [W][W];
  int         pix [W];
  int         n_acc;
  int         exp_m10;
  int         exp_m01;
  bit         exp_v;
  logic [9:0] exp_cx;
  logic [8:0] exp_cy;
  bit         pos_known;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [VW-1:0] obs_vec();
    logic [9:0] ocx;
    logic [8:0] ocy;
    ocx = pos_known ? cx : 10'd0;
    ocy = pos_known ? cy : 9'd0;
`ifdef CENTROID_OCTANT_EN
    return {m10, m01, mom_valid, ocx, ocy, octant};
`else
    return {m10, m01, mom_valid, ocx, ocy};
`endif
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [9:0] ecx;
    logic [8:0] ecy;
    ecx = pos_known ? exp_cx : 10'd0;
    ecy = pos_known ? exp_cy : 9'd0;
`ifdef CENTROID_OCTANT_EN
    begin
      logic [2:0] eo;
      int ax;
      int ay;
      ax = (exp_m10 < 0) ? -exp_m10 : exp_m10;
      ay = (exp_m01 < 0) ? -exp_m01 : exp_m01;
      eo = {exp_m01 < 0, exp_m10 < 0, ay > ax};
      return {24'(exp_m10), 24'(exp_m01), exp_v, ecx, ecy, eo};
    end
`else
    return {24'(exp_m10), 24'(exp_m01), exp_v, ecx, ecy};
`endif
  endfunction

  task automatic clear_model();
    for (int j = 0; j < W; j++)
      for (int k = 0; k < W; k++) win[j][k] = 0;
    n_acc     = 0;
    exp_m10   = 0;
    exp_m01   = 0;
    exp_v     = 0;
    exp_cx    = '0;
    exp_cy    = '0;
    pos_known = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b0;
    clear_model();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_col(input int v);
    for (int k = 0; k < W; k++) pix[k] = v;
  endtask

  // Drive pix[] for one cycle and advance the reference model
  task automatic drive(input bit e);
    int sa;
    int sb;
    int p;
    int c;
    int r;
    ena = e;
    for (int k = 0; k < W; k++) col_in[k*8 +: 8] = 8'(pix[k]);
    @(posedge clk);
    if (e) begin
      sa = 0;
      sb = 0;
      for (int j = 0; j < W; j++)
        for (int k = 0; k < W; k++) begin
          sa += (j - R) * win[j][k];
          sb += (k - R) * win[j][k];
        end
      exp_m10 = sa;
      exp_m01 = sb;
      if (n_acc > 0) begin
        p = n_acc - 1;
        c = p % IW;
        r = (p / IW) % IH;
        exp_v = (c >= W - 1) && (r >= W - 1);
        exp_cx = 10'(c - R);
        exp_cy = 9'(r - R);
        pos_known = 1;
      end else begin
        exp_v = 0;
        pos_known = 0;
      end
      for (int j = 0; j < W - 1; j++)
        for (int k = 0; k < W; k++) win[j][k] = win[j+1][k];
      for (int k = 0; k < W; k++) win[W-1][k] = pix[k];
      n_acc++;
    end else begin
      exp_v = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    clear_model();
    #2;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_uniform();
    do_reset();
    set_col(255);
    for (int i = 0; i < 36 * IW + 37; i++) begin
      drive(1'b1);
      if ((n_acc % IW) < 40 || (n_acc % IW) > 630) begin
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL uniform_stream n=%0d: got %h want %h",
                   n_acc, obs_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (mom_valid !== 1'b0) begin
      errors++;
      $display("FAIL uniform_r36c35_valid: got %b want 0", mom_valid);
    end
    drive(1'b1);
    checks++;
    if ({mom_valid, cx, cy, m10, m01} !== {1'b1, 10'd18, 9'd18, 24'd0, 24'd0}) begin
      errors++;
      $display("FAIL uniform_r36c36: got v=%b cx=%0d cy=%0d m10=%0d m01=%0d want 1 18 18 0 0",
               mom_valid, cx, cy, m10, m01);
    end
  endtask

  task automatic test_midframe_reset();
    set_col(255);
    while (n_acc < 50 * IW + 301) begin
      drive(1'b1);
      if ((n_acc % IW) < 40) begin
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL midframe_pre n=%0d: got %h want %h",
                   n_acc, obs_vec(), exp_vec());
        end
      end
    end
    #2 rst = 1'b0;
    clear_model();
    #1;
    checks++;
    if ({m10, m01, mom_valid, cx, cy} !== '0) begin
      errors++;
      $display("FAIL midframe_async_clear: got m10=%0d m01=%0d v=%b cx=%0d cy=%0d want 0",
               m10, m01, mom_valid, cx, cy);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 36 * IW + 37; i++) begin
      drive(1'b1);
      if ((n_acc % IW) < 40) begin
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL midframe_post n=%0d: got %h want %h",
                   n_acc, obs_vec(), exp_vec());
        end
      end
    end
    drive(1'b1);
    checks++;
    if ({mom_valid, cx, cy} !== {1'b1, 10'd18, 9'd18}) begin
      errors++;
      $display("FAIL midframe_first_valid: got v=%b cx=%0d cy=%0d want 1 18 18",
               mom_valid, cx, cy);
    end
  endtask

  task automatic test_bottom_lane();
    do_reset();
    set_col(0);
    pix[W-1] = 100;
    for (int i = 0; i < 60; i++) begin
      drive(1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bottom_lane i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (m01 !== 24'sd66600 || m10 !== 24'sd0) begin
      errors++;
      $display("FAIL bottom_lane_steady: got m01=%0d m10=%0d want 66600 0", m01, m10);
    end
  endtask

  task automatic test_impulse();
    do_reset();
    set_col(0);
    drive(1'b1);
    pix[R] = 200;
    drive(1'b1);
    set_col(0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL impulse_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      checks++;
      if (m10 !== 24'((i < W) ? 3600 - 200 * i : 0) || m01 !== 24'sd0) begin
        errors++;
        $display("FAIL impulse_step i=%0d: got m10=%0d m01=%0d want %0d 0",
                 i, m10, m01, (i < W) ? 3600 - 200 * i : 0);
      end
    end
  endtask

  task automatic test_stall();
    bit e;
    do_reset();
    for (int i = 0; i < 160; i++) begin
      e = (i % 4 == 0) || (i % 4 == 3);
      for (int k = 0; k < W; k++) pix[k] = (i + 3 * k) & 255;
      drive(e);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall i=%0d ena=%b: got %h want %h", i, e, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      e = ($urandom % 4) != 0;
      for (int k = 0; k < W; k++) pix[k] = int'($urandom_range(255, 0));
      drive(e);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

`ifdef CENTROID_OCTANT_EN
  task automatic test_octant();
    do_reset();
    for (int i = 0; i < W + 1; i++) begin
      set_col(0);
      if (i < R)
        for (int k = 0; k < R; k++) pix[k] = 200;
      drive(1'b1);
    end
    checks++;
    if (!(m10 < 0) || !(m01 < 0) || octant[2:1] !== 2'b11) begin
      errors++;
      $display("FAIL octant_top_left: got m10=%0d m01=%0d oct=%b want neg neg 11x",
               m10, m01, octant);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL octant_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bottom_lane();
    test_impulse();
    test_stall();
    test_random();
`ifdef CENTROID_OCTANT_EN
    test_octant();
`endif
    test_uniform();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
